// File: rtl/el2_exu_noc_result_receiver_pkg.sv
// NoC receiver helpers: flit/pad sizing and pointer-width functions.
// No ports; imported by the result receiver, its FIFO and interface users.
package noc_types;

    function automatic int flits_per_packet(input int bits, input int flit_bits);
        return (bits + flit_bits - 1) / flit_bits;
    endfunction

    function automatic int pad_bits(input int bits, input int flit_bits);
        return flits_per_packet(bits, flit_bits) * flit_bits - bits;
    endfunction

    // Width of an index into n entries, never below one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/el2_exu_noc_result_receiver_if.sv
// Flit-in / result-out handshake bundle of the NoC result receiver.
// master: NoC sender + EXU consumer side; slave: the receiver.
interface el2_exu_noc_result_receiver_if #(
    parameter int PACKET_BITS = 32,
    parameter int FLIT_BITS   = 8,
    parameter int TAG_BITS    = 2
);
    logic                   flit_valid;
    logic [FLIT_BITS-1:0]   flit_data;
    logic                   flit_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [PACKET_BITS-1:0] out_data;
    logic [TAG_BITS-1:0]    out_tag;

    modport master (
        output flit_valid, flit_data, out_ready,
        input  flit_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  flit_valid, flit_data, out_ready,
        output flit_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/el2_noc_result_fifo.sv
// Sync FIFO, any DEPTH >= 1, same-cycle push/pop (legal when full), flush.
// Ports: clk, rst, flush, push/din, pop/dout, count, full.
module el2_noc_result_fifo
    import noc_types::*;
#(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full
);
    localparam int PW = idx_bits(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr, wptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    // Pops on empty are ignored; a pop frees the slot a full push needs.
    assign do_pop  = pop && (count != '0) && !flush && !rst;
    assign do_push = push && (!full || do_pop) && !flush && !rst;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= nxt(wptr);
            if (do_pop)  rptr <= nxt(rptr);
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/el2_exu_noc_result_receiver.sv
// Deserialises LSB-first flits into {tag, payload} results and buffers them.
// Ports: clk, rst, flush, io (flit in / result out), out_padding, busy.
module el2_exu_noc_result_receiver
    import noc_types::*;
#(
    parameter int PACKET_BITS = 32,
    parameter int FLIT_BITS   = 8,
    parameter int TAG_BITS    = 2,
    parameter int DEPTH       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    el2_exu_noc_result_receiver_if.slave io,
    output logic [$clog2(FLIT_BITS):0] out_padding,
    output logic                       busy
);
    localparam int W      = PACKET_BITS + TAG_BITS;
    localparam int NFLITS = flits_per_packet(W, FLIT_BITS);
    localparam int PAD    = pad_bits(W, FLIT_BITS);
    localparam int PADW   = $clog2(FLIT_BITS) + 1;
    localparam int CW     = idx_bits(NFLITS);
    localparam logic [CW-1:0] LAST = CW'(NFLITS - 1);

    typedef struct packed {
        logic [TAG_BITS-1:0]    tag;
        logic [PACKET_BITS-1:0] payload;
    } result_t;

    logic [CW-1:0]              cnt_q;
    logic [$clog2(DEPTH+1)-1:0] fifo_cnt;
    result_t                    pkt, head;
    logic                       full, fire, last_f, pop;

    assign pop    = io.out_valid && io.out_ready;
    assign fire   = io.flit_valid && io.flit_ready;
    assign last_f = fire && (cnt_q == LAST);

    // Only the final flit can stall; a same-cycle pop makes room for it.
    assign io.flit_ready = !rst && !flush &&
                           ((cnt_q != LAST) || !full || pop);

    always_ff @(posedge clk) begin
        if (rst || flush)
            cnt_q <= '0;
        else if (fire)
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    if (NFLITS > 1) begin : g_asm
        logic [(NFLITS-1)*FLIT_BITS-1:0] asm_q;

        always_ff @(posedge clk) begin
            if (fire && (cnt_q != LAST))
                asm_q[int'(cnt_q)*FLIT_BITS +: FLIT_BITS] <= io.flit_data;
        end

        // Final flit supplies the top bits; pad bits drop off here.
        assign pkt = result_t'(W'({io.flit_data, asm_q}));
    end else begin : g_direct
        assign pkt = result_t'(W'(io.flit_data));
    end

    el2_noc_result_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (last_f),
        .din   (pkt),
        .pop   (pop),
        .dout  (head),
        .count (fifo_cnt),
        .full  (full)
    );

    assign io.out_valid = !rst && (fifo_cnt != '0);
    assign io.out_data  = head.payload;
    assign io.out_tag   = head.tag;
    assign busy         = !rst && (cnt_q != '0);
    assign out_padding  = PADW'(PAD);
endmodule
